writeback_commit: RTL
=====================

Name: writeback_commit

Overview:
- Final pipeline stage; consumes the REG_MEM_WB register produced by the memory stage.
- Drives the integer register-file write port and the WB-stage forwarding source.
- Serialises up to three CSR writes per instruction (trap entry: mstatus, mepc, mcause) onto a single-port CSR file, stalling the pipeline while doing so.
- Emits exactly one registered commit record per retired instruction.

Parameters:
- XLEN, 64, datapath width.
- NREG_W, 5, register index width.
- CSR_ADDR_W, 12, CSR address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- moduleIn  in  REG_MEM_WB  MEM/WB pipeline register contents
- ok_to_proceed_overall  in  1  global advance; MEM/WB register reloads on this cycle's edge
- ok_to_proceed  out  1  low while the CSR sequencer still owes writes
- forwardSource  out  FORWARD_SOURCE  WB-stage forwarding (valid, isWb, wd, wdData)
- rf_we  out  1  register-file write enable
- rf_wa  out  NREG_W  register-file write index
- rf_wd  out  XLEN  register-file write data
- csr_we  out  1  CSR write enable
- csr_waddr  out  CSR_ADDR_W  CSR write address
- csr_wdata  out  XLEN  CSR write data
- commit_valid  out  1  one-cycle retire pulse
- commit_pc  out  XLEN  retired instrAddr
- commit_instr  out  32  retired instruction
- commit_wen  out  1  retired instruction wrote rd
- commit_wdst  out  NREG_W  retired rd
- commit_wdata  out  XLEN  retired rd data
- commit_skip  out  1  copy of moduleIn.skip

Behaviour:
- wbData is combinational: memOut if isMemRead; else pcPlus4 if isJump; else aluOut.
- "live" = moduleIn.valid & ~done.
- done is a flag: set on the edge where the instruction finishes; cleared on any edge with ok_to_proceed_overall=1. This prevents double commit while MEM/WB is held by a stall elsewhere.
- rf_we = live & isWriteBack & wd!=0 & state==S_CSR1. rf_wa = wd; rf_wd = wbData (combinational, same cycle).
- forwardSource:
  - valid = moduleIn.valid & wd!=0
  - isWb = isWriteBack
  - wd = wd
  - wdData = wbData
  - Remains valid while done=1.
- FSM states: S_CSR1 (reset), S_CSR2, S_CSR3.
  - S_CSR1:
    - csr_we = live & isCSRWrite; address/data from CSR_addr / CSR_write_value.
    - If live & isCSRWrite2: go to S_CSR2 and hold ok_to_proceed=0.
    - Otherwise instruction finishes this cycle.
  - S_CSR2:
    - csr_we=1 with CSR_addr2 / CSR_write_value2.
    - Go to S_CSR3 if isCSRWrite3, else finish and return to S_CSR1.
    - ok_to_proceed=0.
  - S_CSR3:
    - csr_we=1 with CSR_addr3 / CSR_write_value3.
    - Finish, return to S_CSR1. ok_to_proceed=1 in this cycle.
- ok_to_proceed = (state==S_CSR1 & ~(live & isCSRWrite2)) | state==S_CSR3. It is 1 when moduleIn.valid=0.
- Finish edge:
  - done<=1 unless ok_to_proceed_overall=1 on the same edge (clear wins, since the next instruction loads).
  - Commit record registered: commit_valid=1 on the following cycle, for exactly one cycle.
  - commit_wen = isWriteBack & wd!=0.
- Invalid input: no rf/CSR write, no commit, FSM stays in S_CSR1.
- isCSRWrite3 without isCSRWrite2 is treated as isCSRWrite2=0 (no third write).
- Reset (asynchronous, any time including mid-sequence):
  - state=S_CSR1, done=0.
  - All commit_* outputs = 0.
  - Combinational outputs are then 0 whenever moduleIn.valid=0.

Optional Feature:
- WB_COMMIT_TRACE_EN
  - Defined: commit_* outputs are driven as above.
  - Undefined: commit_* outputs are tied to 0 and the commit registers are removed. rf/CSR/forwarding behaviour is identical.

Decomposition:
- Shared common package (REG_MEM_WB and FORWARD_SOURCE already live there): add wb_state_t (S_CSR1/S_CSR2/S_CSR3) and the commit_rec_t struct.
- Natural sub-module: wb_csr_sequencer, containing the FSM plus the csr_* muxing. The top level keeps the done flag, rf port and commit register.

Test Plan:
- ADD x5=0x1234, valid, ok_to_proceed_overall=1 -> same cycle rf_we=1, rf_wa=5, rf_wd=0x1234; next cycle commit_valid=1, commit_wdata=0x1234.
- LD x7, memOut=0xDEAD, aluOut=0x80000010 -> rf_wd=0xDEAD; forwardSource.wdData=0xDEAD.
- Trap record (isCSRWrite/2/3 set, addrs 0x300/0x341/0x342) -> csr_waddr 0x300, 0x341, 0x342 on three consecutive cycles; ok_to_proceed=0,0,1; single commit pulse.
- MRET (isCSRWrite only, 0x300) -> one CSR write; ok_to_proceed stays 1; FSM stays in S_CSR1.
- ADD x3 held 4 cycles with ok_to_proceed_overall=0 -> rf_we high cycle 1 only; exactly one commit_valid; forwardSource valid all 4 cycles.
- rst_n pulsed low while in S_CSR2 -> state S_CSR1, no csr_we, commit_valid=0 immediately; wd=0 instruction -> rf_we=0, commit_wen=0.

Source files
------------

// File: rtl/writeback_commit_pkg.sv
// Shared pipeline types for the writeback stage: MEM/WB register, forwarding source,
// CSR sequencer state and the registered commit record.
package writeback_commit_pkg;

    localparam int XLEN       = 64;
    localparam int NREG_W     = 5;
    localparam int CSR_ADDR_W = 12;

    typedef struct packed {
        logic                  valid;
        logic                  skip;
        logic [XLEN-1:0]       instrAddr;
        logic [31:0]           instr;
        logic [XLEN-1:0]       pcPlus4;
        logic [XLEN-1:0]       aluOut;
        logic [XLEN-1:0]       memOut;
        logic                  isMemRead;
        logic                  isJump;
        logic                  isWriteBack;
        logic [NREG_W-1:0]     wd;
        logic                  isCSRWrite;
        logic                  isCSRWrite2;
        logic                  isCSRWrite3;
        logic [CSR_ADDR_W-1:0] CSR_addr;
        logic [CSR_ADDR_W-1:0] CSR_addr2;
        logic [CSR_ADDR_W-1:0] CSR_addr3;
        logic [XLEN-1:0]       CSR_write_value;
        logic [XLEN-1:0]       CSR_write_value2;
        logic [XLEN-1:0]       CSR_write_value3;
    } REG_MEM_WB;

    typedef struct packed {
        logic              valid;
        logic              isWb;
        logic [NREG_W-1:0] wd;
        logic [XLEN-1:0]   wdData;
    } FORWARD_SOURCE;

    typedef enum logic [1:0] {
        S_CSR1 = 2'd0,
        S_CSR2 = 2'd1,
        S_CSR3 = 2'd2
    } wb_state_t;

    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   pc;
        logic [31:0]       instr;
        logic              wen;
        logic [NREG_W-1:0] wdst;
        logic [XLEN-1:0]   wdata;
        logic              skip;
    } commit_rec_t;

    // Load data beats link address, which beats the ALU result.
    function automatic logic [XLEN-1:0] wb_select(input REG_MEM_WB r);
        if (r.isMemRead) begin
            return r.memOut;
        end else if (r.isJump) begin
            return r.pcPlus4;
        end
        return r.aluOut;
    endfunction

endpackage

// File: rtl/writeback_commit_csr_sequencer.sv
// Serialises up to three CSR writes of one instruction onto a single-port CSR file
// and reports when the instruction has finished writeback.
module writeback_commit_csr_sequencer
    import writeback_commit_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  live,
    input  logic                  wr1,
    input  logic                  wr2,
    input  logic                  wr3,
    input  logic [CSR_ADDR_W-1:0] addr1,
    input  logic [CSR_ADDR_W-1:0] addr2,
    input  logic [CSR_ADDR_W-1:0] addr3,
    input  logic [XLEN-1:0]       data1,
    input  logic [XLEN-1:0]       data2,
    input  logic [XLEN-1:0]       data3,
    output logic                  csr_we,
    output logic [CSR_ADDR_W-1:0] csr_waddr,
    output logic [XLEN-1:0]       csr_wdata,
    output logic                  ok_to_proceed,
    output logic                  finish,
    output logic                  in_first
);

    wb_state_t state_q, state_d;
    logic      chain2;

    // A third write is only reachable through the second, so wr3 alone is ignored.
    assign chain2   = live & wr2;
    assign in_first = (state_q == S_CSR1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_CSR1;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_CSR1:  if (chain2) state_d = S_CSR2;
            S_CSR2:  state_d = wr3 ? S_CSR3 : S_CSR1;
            S_CSR3:  state_d = S_CSR1;
            default: state_d = S_CSR1;
        endcase
    end

    always_comb begin
        csr_we        = 1'b0;
        csr_waddr     = '0;
        csr_wdata     = '0;
        ok_to_proceed = 1'b0;
        finish        = 1'b0;
        case (state_q)
            S_CSR1: begin
                csr_we        = live & wr1;
                ok_to_proceed = ~chain2;
                finish        = live & ~wr2;
                if (csr_we) begin
                    csr_waddr = addr1;
                    csr_wdata = data1;
                end
            end
            S_CSR2: begin
                csr_we    = 1'b1;
                csr_waddr = addr2;
                csr_wdata = data2;
                finish    = ~wr3;
            end
            S_CSR3: begin
                csr_we        = 1'b1;
                csr_waddr     = addr3;
                csr_wdata     = data3;
                ok_to_proceed = 1'b1;
                finish        = 1'b1;
            end
            default: ok_to_proceed = 1'b1;
        endcase
    end

endmodule

// File: rtl/writeback_commit.sv
// Writeback/commit stage: register-file write, WB forwarding, CSR sequencing and
// the retire record (commit_* live only when WB_COMMIT_TRACE_EN is defined).
module writeback_commit
    import writeback_commit_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  REG_MEM_WB             moduleIn,
    input  logic                  ok_to_proceed_overall,
    output logic                  ok_to_proceed,
    output FORWARD_SOURCE         forwardSource,
    output logic                  rf_we,
    output logic [NREG_W-1:0]     rf_wa,
    output logic [XLEN-1:0]       rf_wd,
    output logic                  csr_we,
    output logic [CSR_ADDR_W-1:0] csr_waddr,
    output logic [XLEN-1:0]       csr_wdata,
    output logic                  commit_valid,
    output logic [XLEN-1:0]       commit_pc,
    output logic [31:0]           commit_instr,
    output logic                  commit_wen,
    output logic [NREG_W-1:0]     commit_wdst,
    output logic [XLEN-1:0]       commit_wdata,
    output logic                  commit_skip
);

    logic            done_q, done_d;
    logic            live;
    logic            finish;
    logic            in_first;
    logic            wd_nz;
    logic [XLEN-1:0] wb_data;

    assign wb_data = wb_select(moduleIn);
    assign wd_nz   = (moduleIn.wd != '0);
    assign live    = moduleIn.valid & ~done_q;

    writeback_commit_csr_sequencer u_seq (
        .clk           (clk),
        .rst_n         (rst_n),
        .live          (live),
        .wr1           (moduleIn.isCSRWrite),
        .wr2           (moduleIn.isCSRWrite2),
        .wr3           (moduleIn.isCSRWrite3),
        .addr1         (moduleIn.CSR_addr),
        .addr2         (moduleIn.CSR_addr2),
        .addr3         (moduleIn.CSR_addr3),
        .data1         (moduleIn.CSR_write_value),
        .data2         (moduleIn.CSR_write_value2),
        .data3         (moduleIn.CSR_write_value3),
        .csr_we        (csr_we),
        .csr_waddr     (csr_waddr),
        .csr_wdata     (csr_wdata),
        .ok_to_proceed (ok_to_proceed),
        .finish        (finish),
        .in_first      (in_first)
    );

    // done blocks a second retire while MEM/WB is frozen; a reload always clears it.
    always_comb begin
        done_d = done_q;
        if (finish) begin
            done_d = 1'b1;
        end
        if (ok_to_proceed_overall) begin
            done_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q <= 1'b0;
        end else begin
            done_q <= done_d;
        end
    end

    assign rf_we = live & moduleIn.isWriteBack & wd_nz & in_first;
    assign rf_wa = moduleIn.valid ? moduleIn.wd : '0;
    assign rf_wd = moduleIn.valid ? wb_data : '0;

    // Forwarding stays valid after retire so held consumers still see the result.
    always_comb begin
        forwardSource = '0;
        if (moduleIn.valid) begin
            forwardSource.valid  = wd_nz;
            forwardSource.isWb   = moduleIn.isWriteBack;
            forwardSource.wd     = moduleIn.wd;
            forwardSource.wdData = wb_data;
        end
    end

`ifdef WB_COMMIT_TRACE_EN
    commit_rec_t commit_q, commit_d;

    always_comb begin
        commit_d = '0;
        if (finish) begin
            commit_d.valid = 1'b1;
            commit_d.pc    = moduleIn.instrAddr;
            commit_d.instr = moduleIn.instr;
            commit_d.wen   = moduleIn.isWriteBack & wd_nz;
            commit_d.wdst  = moduleIn.wd;
            commit_d.wdata = wb_data;
            commit_d.skip  = moduleIn.skip;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            commit_q <= '0;
        end else begin
            commit_q <= commit_d;
        end
    end

    assign commit_valid = commit_q.valid;
    assign commit_pc    = commit_q.pc;
    assign commit_instr = commit_q.instr;
    assign commit_wen   = commit_q.wen;
    assign commit_wdst  = commit_q.wdst;
    assign commit_wdata = commit_q.wdata;
    assign commit_skip  = commit_q.skip;
`else
    logic unused_trace;
    assign unused_trace = ^{moduleIn.skip, moduleIn.instrAddr, moduleIn.instr};

    assign commit_valid = 1'b0;
    assign commit_pc    = '0;
    assign commit_instr = '0;
    assign commit_wen   = 1'b0;
    assign commit_wdst  = '0;
    assign commit_wdata = '0;
    assign commit_skip  = 1'b0;
`endif

endmodule
